ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding front end for the 16-bit signed ALU. It captures decoded operands and ALU control from decode and resolves RAW hazards by forwarding from EX/MEM and MEM/WB, including implicit R15 writes from mul/div. It inserts a one-cycle bubble on load-use hazards and drives the ALU `a`, `b` and `ctrl` inputs directly.

---
 rtl/ex_operand_stage.sv | 154 +++++++++++++++
 tb/tb_ex_operand_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubble insertion.
// Optional feature: define EXOP_DIV0_TRAP_EN to add the div0_trap output and divide-by-zero squash.
module ex_operand_stage #(
    parameter int W  = 16,
    parameter int RA = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [3:0]    id_ctrl,
    input  logic [RA-1:0] id_rs_a,
    input  logic [RA-1:0] id_rs_b,
    input  logic [W-1:0]  id_a,
    input  logic [W-1:0]  id_b,
    input  logic [W-1:0]  id_imm,
    input  logic          id_use_imm,
    input  logic [RA-1:0] id_rd,
    input  logic          id_wr,
    input  logic          id_load,
    input  logic          xm_valid,
    input  logic          xm_wr,
    input  logic          xm_r15_wr,
    input  logic [RA-1:0] xm_rd,
    input  logic [W-1:0]  xm_res,
    input  logic [W-1:0]  xm_r15,
    input  logic          mw_valid,
    input  logic          mw_wr,
    input  logic          mw_r15_wr,
    input  logic [RA-1:0] mw_rd,
    input  logic [W-1:0]  mw_res,
    input  logic [W-1:0]  mw_r15,
    input  logic          hold,
    input  logic          flush,
    output logic          ex_valid,
    output logic [W-1:0]  ex_a,
    output logic [W-1:0]  ex_b,
    output logic [3:0]    ex_ctrl,
    output logic [RA-1:0] ex_rd,
    output logic          ex_wr,
    output logic          ex_load,
    output logic          stall_id,
    output logic          illegal_op
`ifdef EXOP_DIV0_TRAP_EN
    ,
    output logic          div0_trap
`endif
);

    localparam logic [RA-1:0] R15     = RA'(15);
    localparam logic [3:0]    OP_ADD  = 4'b0000;
    localparam logic [3:0]    OP_DIV  = 4'b0011;
    localparam logic [3:0]    OP_LAST = 4'b0101;

    typedef struct packed {
        logic          valid;
        logic [3:0]    ctrl;
        logic [RA-1:0] rs_a;
        logic [RA-1:0] rs_b;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          use_imm;
        logic [RA-1:0] rd;
        logic          wr;
        logic          load;
    } slot_t;

    slot_t slot_q;
    logic  illegal_q;
    logic  load_use;

    // Returns {hit, value}; the implicit R15 write of mul/div outranks the rd write.
    function automatic logic [W:0] stage_sel(
        input logic [RA-1:0] rs,
        input logic          v,
        input logic          wr,
        input logic          r15_wr,
        input logic [RA-1:0] rd,
        input logic [W-1:0]  res,
        input logic [W-1:0]  r15
    );
        if (v && r15_wr && (rs == R15)) return {1'b1, r15};
        if (v && wr && (rd == rs))      return {1'b1, res};
        return '0;
    endfunction

    assign load_use = slot_q.valid && slot_q.load && slot_q.wr && id_valid &&
                      ((id_rs_a == slot_q.rd) || (!id_use_imm && (id_rs_b == slot_q.rd)));

    assign stall_id = !rst && (hold || load_use);

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        illegal_q <= 1'b0;
        if (rst || flush) begin
            slot_q <= '0;
        end else if (hold) begin
            slot_q <= slot_q;
        end else if (load_use) begin
            slot_q <= '0;
        end else if (id_valid && (id_ctrl > OP_LAST)) begin
            slot_q    <= '0;
            illegal_q <= 1'b1;
        end else begin
            slot_q.valid   <= id_valid;
            slot_q.ctrl    <= id_ctrl;
            slot_q.rs_a    <= id_rs_a;
            slot_q.rs_b    <= id_rs_b;
            slot_q.a       <= id_a;
            slot_q.b       <= id_use_imm ? id_imm : id_b;
            slot_q.use_imm <= id_use_imm;
            slot_q.rd      <= id_rd;
            slot_q.wr      <= id_wr;
            slot_q.load    <= id_load;
        end
    end

    logic [W:0]   xm_a_sel, mw_a_sel, xm_b_sel, mw_b_sel;
    logic [W-1:0] fwd_a, fwd_b;

    always_comb begin
        xm_a_sel = stage_sel(slot_q.rs_a, xm_valid, xm_wr, xm_r15_wr, xm_rd, xm_res, xm_r15);
        mw_a_sel = stage_sel(slot_q.rs_a, mw_valid, mw_wr, mw_r15_wr, mw_rd, mw_res, mw_r15);
        xm_b_sel = stage_sel(slot_q.rs_b, xm_valid, xm_wr, xm_r15_wr, xm_rd, xm_res, xm_r15);
        mw_b_sel = stage_sel(slot_q.rs_b, mw_valid, mw_wr, mw_r15_wr, mw_rd, mw_res, mw_r15);

        fwd_a = xm_a_sel[W] ? xm_a_sel[W-1:0] :
                mw_a_sel[W] ? mw_a_sel[W-1:0] : slot_q.a;

        if (slot_q.use_imm) fwd_b = slot_q.b;
        else                fwd_b = xm_b_sel[W] ? xm_b_sel[W-1:0] :
                                    mw_b_sel[W] ? mw_b_sel[W-1:0] : slot_q.b;
    end

    always_comb begin
        ex_valid = slot_q.valid;
        ex_a     = slot_q.valid ? fwd_a : '0;
        ex_b     = slot_q.valid ? fwd_b : '0;
        ex_ctrl  = slot_q.valid ? slot_q.ctrl : OP_ADD;
`ifdef EXOP_DIV0_TRAP_EN
        div0_trap = slot_q.valid && (slot_q.ctrl == OP_DIV) && (fwd_b == '0);
        // Squash to add with b=0 so the ALU passes a through and leaves R15 alone.
        if (div0_trap) begin
            ex_ctrl = OP_ADD;
            ex_b    = '0;
        end
`endif
    end

    assign ex_rd      = slot_q.rd;
    assign ex_wr      = slot_q.wr;
    assign ex_load    = slot_q.load;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed table-driven bench for ex_operand_stage plus hand sequences for stall, hold, flush and reset.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_imm, id_wr, id_load;
    logic [3:0]  id_ctrl, id_rs_a, id_rs_b, id_rd;
    logic [15:0] id_a, id_b, id_imm;
    logic        xm_valid, xm_wr, xm_r15_wr;
    logic [3:0]  xm_rd;
    logic [15:0] xm_res, xm_r15;
    logic        mw_valid, mw_wr, mw_r15_wr;
    logic [3:0]  mw_rd;
    logic [15:0] mw_res, mw_r15;
    logic        hold, flush;
    logic        ex_valid, ex_wr, ex_load, stall_id, illegal_op;
    logic [15:0] ex_a, ex_b;
    logic [3:0]  ex_ctrl, ex_rd;
`ifdef EXOP_DIV0_TRAP_EN
    logic        div0_trap;
    localparam logic [3:0] DIV_EXP = 4'h0;
`else
    localparam logic [3:0] DIV_EXP = 4'h3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.W(16), .RA(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ctrl(id_ctrl), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
        .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
        .xm_valid(xm_valid), .xm_wr(xm_wr), .xm_r15_wr(xm_r15_wr), .xm_rd(xm_rd),
        .xm_res(xm_res), .xm_r15(xm_r15),
        .mw_valid(mw_valid), .mw_wr(mw_wr), .mw_r15_wr(mw_r15_wr), .mw_rd(mw_rd),
        .mw_res(mw_res), .mw_r15(mw_r15),
        .hold(hold), .flush(flush),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_ctrl(ex_ctrl),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_load(ex_load),
        .stall_id(stall_id), .illegal_op(illegal_op)
`ifdef EXOP_DIV0_TRAP_EN
        , .div0_trap(div0_trap)
`endif
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [3:0]  rs_a, rs_b;
        logic [15:0] a, b, imm;
        logic        use_imm;
        logic        xv, xw, xr;
        logic [3:0]  xrd;
        logic [15:0] xres, xr15;
        logic        mv, mww, mr;
        logic [3:0]  mrd;
        logic [15:0] mres, mr15;
        logic        e_valid;
        logic [15:0] e_a, e_b;
        logic [3:0]  e_ctrl;
        logic        e_ill;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_ctrl = 4'h0; id_rs_a = 4'h0; id_rs_b = 4'h0;
        id_a = 16'h0; id_b = 16'h0; id_imm = 16'h0; id_use_imm = 1'b0;
        id_rd = 4'h0; id_wr = 1'b0; id_load = 1'b0;
        xm_valid = 1'b0; xm_wr = 1'b0; xm_r15_wr = 1'b0; xm_rd = 4'h0;
        xm_res = 16'h0; xm_r15 = 16'h0;
        mw_valid = 1'b0; mw_wr = 1'b0; mw_r15_wr = 1'b0; mw_rd = 4'h0;
        mw_res = 16'h0; mw_r15 = 16'h0;
        hold = 1'b0; flush = 1'b0;
    endtask

    task automatic set_id(input logic [3:0] ctrl, input logic [3:0] rs_a, input logic [3:0] rs_b,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] rd, input logic load);
        id_valid = 1'b1; id_ctrl = ctrl; id_rs_a = rs_a; id_rs_b = rs_b;
        id_a = a; id_b = b; id_imm = 16'h0; id_use_imm = 1'b0;
        id_rd = rd; id_wr = 1'b1; id_load = load;
    endtask

    initial begin
        vecs[0]  = '{4'h0, 4'd1, 4'd2, 16'h0005, 16'h0003, 16'h0000, 1'b0,
                     1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000,
                     1'b1, 16'h0005, 16'h0003, 4'h0, 1'b0};
        vecs[1]  = '{4'h0, 4'd1, 4'd2, 16'h1111, 16'h0003, 16'h0000, 1'b0,
                     1'b1, 1'b1, 1'b0, 4'd1, 16'h0010, 16'h0000,
                     1'b1, 1'b1, 1'b0, 4'd1, 16'h0020, 16'h0000,
                     1'b1, 16'h0010, 16'h0003, 4'h0, 1'b0};
        vecs[2]  = '{4'h0, 4'd1, 4'd2, 16'h1111, 16'h0003, 16'h0000, 1'b0,
                     1'b0, 1'b1, 1'b0, 4'd1, 16'h0010, 16'h0000,
                     1'b1, 1'b1, 1'b0, 4'd1, 16'h0020, 16'h0000,
                     1'b1, 16'h0020, 16'h0003, 4'h0, 1'b0};
        vecs[3]  = '{4'h2, 4'd15, 4'd2, 16'h1234, 16'h0002, 16'h0000, 1'b0,
                     1'b1, 1'b1, 1'b1, 4'd15, 16'h0001, 16'hFFFF,
                     1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000,
                     1'b1, 16'hFFFF, 16'h0002, 4'h2, 1'b0};
        vecs[4]  = '{4'h5, 4'd1, 4'd15, 16'h000A, 16'h0BBB, 16'h0000, 1'b0,
                     1'b1, 1'b1, 1'b0, 4'd15, 16'h0042, 16'h0000,
                     1'b1, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h0099,
                     1'b1, 16'h000A, 16'h0042, 4'h5, 1'b0};
        vecs[5]  = '{4'h1, 4'd3, 4'd1, 16'h0009, 16'h5555, 16'hFFF0, 1'b1,
                     1'b1, 1'b1, 1'b0, 4'd1, 16'h7777, 16'h0000,
                     1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000,
                     1'b1, 16'h0009, 16'hFFF0, 4'h1, 1'b0};
        vecs[6]  = '{4'h0, 4'd2, 4'd3, 16'h00AB, 16'h00CD, 16'h0000, 1'b0,
                     1'b0, 1'b1, 1'b1, 4'd2, 16'hEEEE, 16'hEEEE,
                     1'b0, 1'b1, 1'b1, 4'd3, 16'hDDDD, 16'hDDDD,
                     1'b1, 16'h00AB, 16'h00CD, 4'h0, 1'b0};
        vecs[7]  = '{4'h4, 4'd15, 4'd4, 16'h0000, 16'h00F0, 16'h0000, 1'b0,
                     1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000,
                     1'b1, 1'b1, 1'b1, 4'd15, 16'h0001, 16'h8000,
                     1'b1, 16'h8000, 16'h00F0, 4'h4, 1'b0};
        vecs[8]  = '{4'h7, 4'd1, 4'd2, 16'h0005, 16'h0006, 16'h0000, 1'b0,
                     1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000,
                     1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1};
        vecs[9]  = '{4'h3, 4'd1, 4'd2, 16'h0007, 16'h0000, 16'h0000, 1'b0,
                     1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000,
                     1'b1, 16'h0007, 16'h0000, DIV_EXP, 1'b0};
        vecs[10] = '{4'h4, 4'd1, 4'd2, 16'h0001, 16'h00FF, 16'h0000, 1'b0,
                     1'b1, 1'b0, 1'b0, 4'd1, 16'hDEAD, 16'hBEEF,
                     1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000,
                     1'b1, 16'h0001, 16'h00FF, 4'h4, 1'b0};
        vecs[11] = '{4'h1, 4'd4, 4'd5, 16'h0004, 16'h0005, 16'h0000, 1'b0,
                     1'b1, 1'b1, 1'b0, 4'd5, 16'h0050, 16'h0000,
                     1'b1, 1'b1, 1'b0, 4'd4, 16'h0040, 16'h0000,
                     1'b1, 16'h0040, 16'h0050, 4'h1, 1'b0};
        vecs[12] = '{4'hF, 4'd6, 4'd7, 16'h0101, 16'h0202, 16'h0000, 1'b0,
                     1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000,
                     1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1};
        vecs[13] = '{4'h5, 4'd6, 4'd7, 16'h0101, 16'h0202, 16'h0000, 1'b0,
                     1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000,
                     1'b1, 16'h0101, 16'h0202, 4'h5, 1'b0};

        // Reset with a pending instruction and hold asserted: everything must stay 0.
        idle_inputs();
        rst = 1'b1;
        set_id(4'h0, 4'd1, 4'd2, 16'h0005, 16'h0003, 4'd8, 1'b1);
        hold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst ex_valid", ex_valid, 0);
        check("rst ex_a", ex_a, 0);
        check("rst ex_b", ex_b, 0);
        check("rst ex_ctrl", ex_ctrl, 0);
        check("rst ex_rd", ex_rd, 0);
        check("rst ex_wr", ex_wr, 0);
        check("rst ex_load", ex_load, 0);
        check("rst illegal_op", illegal_op, 0);
        check("rst stall_id", stall_id, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            set_id(vecs[i].ctrl, vecs[i].rs_a, vecs[i].rs_b, vecs[i].a, vecs[i].b, 4'd8, 1'b0);
            id_imm = vecs[i].imm; id_use_imm = vecs[i].use_imm;
            xm_valid = vecs[i].xv; xm_wr = vecs[i].xw; xm_r15_wr = vecs[i].xr;
            xm_rd = vecs[i].xrd; xm_res = vecs[i].xres; xm_r15 = vecs[i].xr15;
            mw_valid = vecs[i].mv; mw_wr = vecs[i].mww; mw_r15_wr = vecs[i].mr;
            mw_rd = vecs[i].mrd; mw_res = vecs[i].mres; mw_r15 = vecs[i].mr15;
            @(posedge clk);
            #1;
            check($sformatf("v%0d ex_valid", i), ex_valid, vecs[i].e_valid);
            check($sformatf("v%0d ex_a", i), ex_a, vecs[i].e_a);
            check($sformatf("v%0d ex_b", i), ex_b, vecs[i].e_b);
            check($sformatf("v%0d ex_ctrl", i), ex_ctrl, vecs[i].e_ctrl);
            check($sformatf("v%0d ex_rd", i), ex_rd, vecs[i].e_valid ? 4'd8 : 4'd0);
            check($sformatf("v%0d ex_wr", i), ex_wr, vecs[i].e_valid);
            check($sformatf("v%0d illegal_op", i), illegal_op, vecs[i].e_ill);
            check($sformatf("v%0d stall_id", i), stall_id, 0);
        end

        // Load-use: one bubble, then the dependent sub takes R3 from MEM/WB.
        @(negedge clk);
        idle_inputs();
        set_id(4'h0, 4'd1, 4'd2, 16'h0001, 16'h0002, 4'd3, 1'b1);
        @(posedge clk);
        #1;
        check("lu ex_load", ex_load, 1);
        @(negedge clk);
        set_id(4'h1, 4'd3, 4'd2, 16'h0BAD, 16'h0004, 4'd4, 1'b0);
        #1;
        check("lu stall_id", stall_id, 1);
        @(posedge clk);
        #1;
        check("lu bubble ex_valid", ex_valid, 0);
        check("lu bubble ex_a", ex_a, 0);
        check("lu stall released", stall_id, 0);
        @(negedge clk);
        mw_valid = 1'b1; mw_wr = 1'b1; mw_rd = 4'd3; mw_res = 16'h0033;
        @(posedge clk);
        #1;
        check("lu sub ex_valid", ex_valid, 1);
        check("lu sub ex_a", ex_a, 16'h0033);
        check("lu sub ex_b", ex_b, 16'h0004);
        check("lu sub ex_ctrl", ex_ctrl, 4'h1);

        // Hold for three cycles freezes the slot; flush then beats hold.
        @(negedge clk);
        idle_inputs();
        set_id(4'h0, 4'd6, 4'd7, 16'h0005, 16'h0003, 4'd8, 1'b0);
        @(posedge clk);
        #1;
        check("hold pre ex_a", ex_a, 16'h0005);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            hold = 1'b1;
            id_ctrl = 4'h1;
            id_a = 16'(100 + i);
            @(posedge clk);
            #1;
            check($sformatf("hold%0d ex_valid", i), ex_valid, 1);
            check($sformatf("hold%0d ex_a", i), ex_a, 16'h0005);
            check($sformatf("hold%0d ex_b", i), ex_b, 16'h0003);
            check($sformatf("hold%0d ex_ctrl", i), ex_ctrl, 4'h0);
            check($sformatf("hold%0d stall_id", i), stall_id, 1);
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush ex_valid", ex_valid, 0);
        check("flush ex_a", ex_a, 0);

        // Reset during a load-use stall releases it.
        @(negedge clk);
        idle_inputs();
        set_id(4'h0, 4'd1, 4'd2, 16'h0001, 16'h0002, 4'd3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_id(4'h1, 4'd3, 4'd2, 16'h0BAD, 16'h0004, 4'd4, 1'b0);
        #1;
        check("rs stall before rst", stall_id, 1);
        rst = 1'b1;
        #1;
        check("rs stall during rst", stall_id, 0);
        @(posedge clk);
        #1;
        check("rs ex_valid", ex_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rs stall after rst", stall_id, 0);
        @(posedge clk);
        #1;
        check("rs sub issued", ex_valid, 1);
        check("rs sub ex_a", ex_a, 16'h0BAD);

`ifdef EXOP_DIV0_TRAP_EN
        @(negedge clk);
        idle_inputs();
        set_id(4'h3, 4'd9, 4'd10, 16'h0007, 16'h0000, 4'd8, 1'b0);
        @(posedge clk);
        #1;
        check("div0 trap", div0_trap, 1);
        check("div0 ex_ctrl", ex_ctrl, 4'h0);
        check("div0 ex_b", ex_b, 16'h0000);
        check("div0 ex_a", ex_a, 16'h0007);
        @(negedge clk);
        id_b = 16'h0002;
        @(posedge clk);
        #1;
        check("div2 trap", div0_trap, 0);
        check("div2 ex_ctrl", ex_ctrl, 4'h3);
        check("div2 ex_b", ex_b, 16'h0002);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
